// File: rtl/apb_reg_slave.sv
// APB register slave: sixteen 32-bit registers in a 64-byte window.
// Index 0 is a read-only count of completed transfers; indices 1..15 are
// read/write storage. Each transfer inserts WAIT_CYCLES access-phase wait
// states before pready_o is raised.
module apb_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CAC0,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [29:0] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [31:0] count_q;
    logic [31:0] regs_q [16];

    logic        setup;
    logic        capture;
    logic        pready;
    logic [3:0]  idx;
    logic        in_win;
    logic        err;
    logic        commit;
    logic [31:0] rd_word;

    assign setup = psel_i && !penable_i;

    // State register and wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic. The counter is checked against 1 rather than 0 so
    // that RESP is itself the last access cycle: pready_o appears in access
    // cycle WAIT_CYCLES+1, and with WAIT_CYCLES=0 setup goes straight to RESP.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        capture = 1'b0;
        pready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    capture = 1'b1;
                    wcnt_d  = WAIT_LOAD;
                    state_d = (WAIT_LOAD == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!psel_i) begin
                    state_d = S_IDLE;
                end else if (wcnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (!psel_i) begin
                    state_d = S_IDLE;
                end else if (penable_i) begin
                    pready  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    capture = 1'b1;
                    wcnt_d  = WAIT_LOAD;
                    state_d = (WAIT_LOAD == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decode of the captured request.
    always_comb begin
        idx     = addr_q[3:0];
        in_win  = (addr_q[29:4] == BASE_ADDR[31:6]);
        err     = !in_win || (write_q && (idx == 4'd0));
        commit  = pready && write_q && !err;
        rd_word = (idx == 4'd0) ? count_q : regs_q[idx];
    end

    // Response outputs: zero unless the transfer is completing.
    always_comb begin
        pready_o  = pready;
        pslverr_o = pready && err;
        prdata_o  = (pready && !write_q && !err) ? rd_word : '0;
    end

    // Request capture in the setup cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (capture) begin
            addr_q  <= paddr_i[31:2];
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
        end
    end

    // Transfer counter and register storage updates on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (pready) begin
                count_q <= count_q + 32'd1;
            end
            if (commit) begin
                regs_q[idx] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Testbench for apb_reg_slave: two instances (WAIT_CYCLES=2 and 0) on a
// shared APB bus, a register-map reference model and a scoreboard monitor.
module tb_apb_reg_slave;

    localparam logic [31:0] BASE = 32'hDEAD_CAC0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  psel = '0;
    logic        penable = 1'b0;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [1:0]  pready;
    logic [1:0]  pslverr;
    logic [31:0] prdata [2];

    always #5 clk = ~clk;

    apb_reg_slave #(.BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .psel_i(psel[0]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0])
    );

    apb_reg_slave #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .psel_i(psel[1]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1])
    );

    typedef struct {
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem [2][16];
    logic [31:0] mcnt [2];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wcyc [2] = '{2, 0};

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = '0;
            for (int i = 0; i < 16; i++) mem[k][i] = '0;
        end
    endfunction

    // Register map behaviour: window check, read-only counter at index 0.
    function automatic void model_xfer(input int k, input logic [31:0] a, input logic w,
                                       input logic [31:0] d, output logic [31:0] rd, output logic er);
        int idx;
        idx = int'(a[5:2]);
        er  = (a[31:6] != BASE[31:6]) || (w && idx == 0);
        rd  = '0;
        if (!er && !w) rd = (idx == 0) ? mcnt[k] : mem[k][idx];
        if (!er && w) mem[k][idx] = d;
        mcnt[k] = mcnt[k] + 32'd1;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        logic have;
        for (int k = 0; k < 2; k++) begin
            if (pready[k]) begin
                have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                check($sformatf("pready_expected%0d", k), 32'(have), 32'd1);
                if (have) begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("prdata%0d", k), prdata[k], e.rd);
                    check($sformatf("pslverr%0d", k), 32'(pslverr[k]), 32'(e.er));
                end
            end else begin
                check($sformatf("prdata_idle%0d", k), prdata[k], 32'd0);
                check($sformatf("pslverr_idle%0d", k), 32'(pslverr[k]), 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            psel = '0; penable = 1'b0;
        end
    endtask

    // One APB transfer. abort_kind 1 drops psel, 2 asserts reset, in access cycle abort_cyc.
    task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int abort_cyc, input int abort_kind, output logic [31:0] rd);
        exp_t e;
        logic done;
        @(posedge clk); #1;
        psel = '0; psel[k] = 1'b1; penable = 1'b0;
        paddr = a; pwrite = w; pwdata = d;
        rd = '0;
        if (abort_cyc == 0) begin
            model_xfer(k, a, w, d, e.rd, e.er);
            rd = e.rd;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk); #1;
        penable = 1'b1;
        paddr = $urandom; pwdata = $urandom;
        done = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            if (cyc == abort_cyc) begin
                if (abort_kind == 1) begin
                    psel[k] = 1'b0; penable = 1'b0;
                    @(negedge clk);
                    check("abort_no_pready", 32'(pready[k]), 32'd0);
                end else begin
                    reset_n = 1'b0;
                    #1;
                    check("rst_pready", 32'(pready), 32'd0);
                    check("rst_pslverr", 32'(pslverr), 32'd0);
                    check("rst_prdata", prdata[0] | prdata[1], 32'd0);
                    repeat (3) @(posedge clk);
                    #1;
                    model_reset();
                    psel = '0; penable = 1'b0;
                    reset_n = 1'b1;
                end
                done = 1'b1;
            end else begin
                @(negedge clk);
                if (pready[k]) begin
                    check($sformatf("latency%0d", k), 32'(cyc), 32'(wcyc[k] + 1));
                    done = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        if (!done) check("pready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        int          k;
        int          ab;
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Read after reset, 3rd access cycle on the 2-wait instance.
        xfer(0, 32'hDEAD_CAFE, 1'b0, '0, 0, 0, v);
        idle(1);
        // Write then read back, then read the counter.
        xfer(0, 32'hDEAD_CAFE, 1'b1, 32'h1234_5679, 0, 0, v);
        idle(1);
        xfer(0, 32'hDEAD_CAFE, 1'b0, '0, 0, 0, v);
        xfer(0, 32'hDEAD_CAC0, 1'b0, '0, 0, 0, v);
        idle(2);
        // Out-of-window and index-0 writes error out.
        xfer(0, 32'hDEAD_C000, 1'b1, 32'h5555_AAAA, 0, 0, v);
        xfer(0, 32'hDEAD_CAC0, 1'b1, 32'h0BAD_F00D, 0, 0, v);
        xfer(0, 32'hDEAD_CAFE, 1'b0, '0, 0, 0, v);
        xfer(0, 32'hDEAD_CAC0, 1'b0, '0, 0, 0, v);
        idle(1);
        // Abort a write during WAIT.
        xfer(0, 32'hDEAD_CAFE, 1'b1, 32'hFFFF_FFFF, 2, 1, v);
        xfer(0, 32'hDEAD_CAFE, 1'b0, '0, 0, 0, v);
        xfer(0, 32'hDEAD_CAC0, 1'b0, '0, 0, 0, v);
        idle(1);
        // Back-to-back read-modify-write on the zero-wait instance.
        for (int i = 0; i < 3; i++) begin
            xfer(1, 32'hDEAD_CAFE, 1'b0, '0, 0, 0, v);
            xfer(1, 32'hDEAD_CAFE, 1'b1, v + 32'd1, 0, 0, v);
        end
        xfer(1, 32'hDEAD_CAFE, 1'b0, '0, 0, 0, v);
        idle(1);
        // Access phase without a setup phase gets no response.
        @(posedge clk); #1;
        psel = 2'b11; penable = 1'b1; paddr = 32'hDEAD_CAC4; pwrite = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        psel = '0; penable = 1'b0;
        idle(1);
        // Reset during WAIT of a write, then everything reads back zero.
        xfer(0, 32'hDEAD_CAF0, 1'b1, 32'hAAAA_5555, 1, 2, v);
        for (int i = 0; i < 16; i++) begin
            xfer(0, BASE + 32'(i * 4), 1'b0, '0, 0, 0, v);
            xfer(1, BASE + 32'(i * 4), 1'b0, '0, 0, 0, v);
        end

        // Randomized traffic.
        repeat (200) begin
            k = int'($urandom_range(1, 0));
            a = ($urandom_range(7, 0) == 0) ? $urandom : {BASE[31:6], 6'($urandom)};
            ab = ($urandom_range(7, 0) == 0) ? int'($urandom_range(wcyc[k] + 1, 1)) : 0;
            xfer(k, a, 1'($urandom), $urandom, ab, 1, v);
            idle(int'($urandom_range(2, 0)));
        end

        idle(3);
        check("queue0_drained", 32'(q0.size()), 32'd0);
        check("queue1_drained", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hDEAD_CAC0, the 64-byte-aligned base of the register window.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, giving the access-phase wait states per transfer (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port psel_i, input, 1 bit: APB select.
REQ-006 SHALL have port penable_i, input, 1 bit: APB enable (access phase).
REQ-007 SHALL have port paddr_i, input, 32 bits: byte address.
REQ-008 SHALL have port pwrite_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port pwdata_i, input, 32 bits: write data.
REQ-010 SHALL have port pready_o, output, 1 bit: transfer completes in the cycle it is high.
REQ-011 SHALL have port prdata_o, output, 32 bits: read data, valid only when pready_o=1 and pwrite_i=0.
REQ-012 SHALL have port pslverr_o, output, 1 bit: error response, valid only when pready_o=1.

Function
REQ-013 SHALL hold 16 x 32-bit registers, index = paddr_i[5:2]; paddr_i[1:0] ignored.
- Example: address 32'hDEAD_CAFE maps to index 15.
REQ-014 SHALL treat an address as in-window when paddr_i[31:6] == BASE_ADDR[31:6].
REQ-015 SHALL make index 0 a read-only transfer counter, incremented (mod 2^32) on every completed transfer, including error transfers.
REQ-016 SHALL make indices 1..15 read/write storage.
REQ-017 SHALL implement a state machine with three states:
- IDLE: psel_i=1 and penable_i=0 (setup phase) -> WAIT, loading the wait counter with WAIT_CYCLES.
- WAIT: counter != 0 -> decrement, pready_o=0; counter == 0 -> RESP.
- RESP: pready_o=1 for exactly one cycle -> IDLE, or -> WAIT if a new setup phase is present in the same cycle.
REQ-018 With WAIT_CYCLES=0, SHALL complete the transfer in the first access-phase cycle (pready_o=1 combinationally in that cycle).
REQ-019 SHALL capture paddr_i, pwrite_i and pwdata_i in the setup cycle and use only the captured values for the transfer.
REQ-020 SHALL commit a write at the rising edge ending the pready_o=1 cycle.
REQ-021 SHALL drive prdata_o from the addressed register when pready_o=1 on a read, and 0 at all other times.
REQ-022 SHALL assert pslverr_o with pready_o when the address is out of window, or on a write to index 0.
- Storage SHALL be unchanged and prdata_o SHALL be 0 in either case.
REQ-023 A read of index 0 SHALL return the count value before the current transfer is counted.
REQ-024 If psel_i deasserts while in WAIT or RESP, SHALL abort to IDLE with no write, no count increment and pready_o=0.
REQ-025 SHALL ignore penable_i=1 seen in IDLE without a preceding setup phase (no response).
REQ-026 pready_o SHALL be 0 in IDLE and WAIT; pslverr_o SHALL be 0 whenever pready_o=0.

Reset
REQ-027 While reset_n=0: state IDLE, pready_o=0, pslverr_o=0, prdata_o=0, all registers and the transfer counter cleared to 0.
REQ-028 Reset SHALL take effect immediately, including mid-transfer; an interrupted write SHALL leave storage cleared.
REQ-029 First setup phase accepted SHALL be on the first rising edge after reset_n rises.

Verification
REQ-030 Read 32'hDEAD_CAFE after reset, WAIT_CYCLES=2 -> pready_o high in the 3rd access cycle, prdata_o=0, pslverr_o=0.
REQ-031 Write 32'h1234_5679 to 32'hDEAD_CAFE, then read the same address -> read returns 32'h1234_5679; reading 32'hDEAD_CAC0 then returns 2.
REQ-032 Write to 32'hDEAD_C000 (out of window), then write to 32'hDEAD_CAC0 -> both complete with pslverr_o=1; storage unchanged; counter advances by 2.
REQ-033 Back-to-back read-modify-write with WAIT_CYCLES=0 (read 0xDEAD_CAFE, write read value+1) repeated 3 times from 0 -> final read returns 3, each transfer completes in 2 cycles.
REQ-034 Drop psel_i during WAIT of a write of 32'hFFFF_FFFF -> no pready_o, register keeps its old value, counter unchanged.
REQ-035 Assert reset_n=0 during WAIT of a write -> outputs 0 immediately; after release, all reads return 0.
